uart_tx_frame: RTL
==================

# uart_tx_frame

UART transmit framer, the send-side counterpart of the receiver's frame error checker. It accepts an 8-bit byte with a parity selection and serialises one frame on `tx_out`: start bit, 8 data bits LSB first, an optional parity bit, then 1 or 2 stop bits. Bit timing comes from an external one-cycle `baud_tick` pulse issued once per bit period. Parity encoding matches the receiver, so frames from this block pass the receiver's error check with `error_flag` = 3'b110.

## Interface
- `STOP_BITS`, default 1: number of stop bits, legal values 1 or 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  one-`clk`-wide pulse, once per bit period.
- `tx_start`  in  1  request to send; sampled every cycle.
- `data_in`  in  8  byte to send; captured on acceptance.
- `parity_type`  in  2  parity select, captured on acceptance:
  - 2'b01: ODD.
  - 2'b10: EVEN.
  - 2'b00 or 2'b11: no parity bit.
- `tx_out`  out  1  serial line, registered; idles high.
- `busy`  out  1  high from acceptance until the frame completes.
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- States:
  - IDLE
  - SYNC: waiting for the first tick.
  - START
  - DATA: 3-bit index 0..7.
  - PARITY
  - STOP: stop-bit counter 0..STOP_BITS-1.
- Acceptance:
  - Accepted when the state is IDLE and `tx_start`=1.
  - Captures `data_in` and `parity_type` into internal registers.
  - Next state is SYNC; `busy` goes to 1.
  - `tx_start` in any other state is ignored; no queueing.
- Bit sequencing:
  - SYNC --tick--> START; `tx_out`=0.
  - START --tick--> DATA idx0; `tx_out`=data[0].
  - DATA idx k --tick--> idx k+1 while k<7; `tx_out`=data[k+1].
  - DATA idx7 --tick--> PARITY when parity is enabled, else STOP.
  - PARITY --tick--> STOP; `tx_out`=1.
  - STOP --tick--> next stop bit while the counter < STOP_BITS-1.
  - Last STOP --tick--> IDLE; `busy`=0, `done`=1.
- Every bit is held on `tx_out` for exactly one tick interval. Nothing changes between ticks.
- Parity bit:
  - ODD: ~^data, so the total count of ones in data plus parity is odd.
  - EVEN: ^data.
  - Computed from the captured byte, not the live `data_in`.
- Changes on `data_in`/`parity_type` after acceptance do not affect the frame in flight.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset mid-frame: outputs return to the reset values immediately (asynchronous). The frame is aborted with no `done`.
- All outputs are registered and change only on a `clk` edge.
- `busy` is 1 from the cycle after acceptance, through the cycle of the last stop-bit tick.
- Latency: the start bit appears one `clk` after the first `baud_tick` following acceptance.
- A tick in the same cycle as acceptance is not counted.
- Frame length in ticks after SYNC:
  - 1 start + 8 data + P + STOP_BITS, where P=1 with parity and 0 without.
  - Range 10..12.
- `done`:
  - Rises in the same cycle that `busy` falls and lasts exactly 1 cycle.
  - `tx_start` in the cycle `done`=1 is accepted; back-to-back frames are allowed.
  - The next start bit begins on the following tick, so there is no idle gap beyond SYNC.
- `baud_tick` high for more than one cycle: each high cycle counts as one tick. Callers must not do this.

## Test plan
- Reset: hold `rst_n`=0, toggle `baud_tick` -> `tx_out`=1, `busy`=0, `done`=0 throughout.
- 0xA5, ODD, STOP_BITS=1:
  - Required `tx_out` per tick: 0, 1,0,1,0,0,1,0,1, 1, 1 (11 ticks).
  - `done` pulses once; the receiver error check on the frame gives `error_flag`=3'b110.
- 0x07, EVEN -> parity bit 1. 0x00, `parity_type`=2'b00 -> 10-tick frame 0, eight 0s, 1, with no parity slot. STOP_BITS=2 adds one extra high tick.
- Capture and ignore: `tx_start` plus a new `data_in`=0x3C pulsed mid-frame -> the frame in flight is unchanged and no second frame follows.
- Back-to-back: `tx_start`=1 held through the `done` cycle -> the second frame starts on the next tick. `busy` is low for exactly 1 cycle.
- Abort: assert `rst_n`=0 during data bit 4 -> `tx_out`=1 and `busy`=0 immediately, no `done`. After release, a new frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   UART transmit framer. Accepts one byte plus a parity selection and
//   serialises a frame on tx_out: start bit (0), 8 data bits LSB first,
//   optional parity bit, then STOP_BITS stop bits (1). Bit timing comes from
//   an external one-cycle baud_tick pulse, one per bit period.
//
// Parameters
//   STOP_BITS    number of stop bits, 1 or 2
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   baud_tick    one-cycle pulse per bit period
//   tx_start     send request, accepted only while idle
//   data_in      byte to send, captured on acceptance
//   parity_type  01 odd, 10 even, 00/11 no parity; captured on acceptance
//   tx_out       registered serial line, idles high
//   busy         high from the cycle after acceptance to frame completion
//   done         one-cycle pulse in the cycle busy falls
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  // Index of the final stop bit; the counter never needs more than one bit.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0] state;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic [7:0] data_q;
  logic [1:0] par_q;

  logic par_en;
  logic par_bit;

  // Only 01 (odd) and 10 (even) carry a parity bit, i.e. exactly one bit set.
  assign par_en  = ^par_q;
  // Odd parity makes the total count of ones (data + parity) odd.
  assign par_bit = (par_q == 2'b01) ? ~^data_q : ^data_q;

  // NOTE: every register here is updated with non-blocking assignments so all
  // next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      data_q   <= 8'h00;
      par_q    <= 2'b00;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A tick coinciding with acceptance is deliberately not counted:
          // SYNC waits for the next one so the start bit is a full period.
          if (tx_start) begin
            data_q <= data_in;
            par_q  <= parity_type;
            busy   <= 1'b1;
            state  <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (baud_tick) begin
            tx_out <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            bit_idx <= 3'd0;
            tx_out  <= data_q[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= data_q[bit_idx + 3'd1];
            end else if (par_en) begin
              tx_out <= par_bit;
              state  <= S_PARITY;
            end else begin
              stop_cnt <= 1'b0;
              tx_out   <= 1'b1;
              state    <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            stop_cnt <= 1'b0;
            tx_out   <= 1'b1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_idx <= 3'd0;
              state   <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
